// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-master RAM arbiter.
package ram_arb_pkg;

    localparam int AW = 6;
    localparam int DW = 8;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; remembers the last accepted master.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    req_id_t r_last_win;

    // Winner pointer moves only when a grant is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_win <= M1;
        end else if (accept) begin
            r_last_win <= gnt[1] ? M1 : M0;
        end
    end

    // Lone requester wins outright; on conflict the previous loser wins.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = (r_last_win == M1) ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and sequencer in front of the 64x8 single-port RAM.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW = ram_arb_pkg::AW,
    parameter int DW = ram_arb_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    logic [1:0]    w_arb_gnt;
    logic [1:0]    w_gnt;
    logic          w_accept;
    req_id_t       w_sel;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    logic          r_ram_we;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_wdata;
    rd_tag_t       r_tag1;
    rd_tag_t       r_tag2;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({req1, req0}),
        .accept (w_accept),
        .gnt    (w_arb_gnt)
    );

    // Grants are forced low while reset is held so nothing is accepted.
    always_comb begin
        w_gnt       = w_arb_gnt & {2{rst_n}};
        w_accept    = |(w_gnt & {req1, req0});
        w_sel       = w_gnt[1] ? M1 : M0;
        w_sel_we    = (w_sel == M1) ? we1 : we0;
        w_sel_addr  = (w_sel == M1) ? addr1 : addr0;
        w_sel_wdata = (w_sel == M1) ? wdata1 : wdata0;
    end

    // RAM port registers; address/data hold when nothing is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_ram_we <= w_accept & w_sel_we;
            if (w_accept) begin
                r_ram_addr <= w_sel_addr;
            end
            if (w_accept && w_sel_we) begin
                r_ram_wdata <= w_sel_wdata;
            end
        end
    end

    // Read tags follow the RAM's two-edge read latency so data and owner line up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag1 <= '{valid: 1'b0, id: M0};
            r_tag2 <= '{valid: 1'b0, id: M0};
        end else begin
            r_tag1.valid <= w_accept & ~w_sel_we;
            r_tag1.id    <= w_sel;
            r_tag2       <= r_tag1;
        end
    end

    // Response demux: only the owner sees data, the other port reads zero.
    always_comb begin
        gnt0      = w_gnt[0];
        gnt1      = w_gnt[1];
        rvalid0   = r_tag2.valid && (r_tag2.id == M0);
        rvalid1   = r_tag2.valid && (r_tag2.id == M1);
        rdata0    = rvalid0 ? ram_rdata : '0;
        rdata1    = rvalid1 ? ram_rdata : '0;
        ram_we    = r_ram_we;
        ram_addr  = r_ram_addr;
        ram_wdata = r_ram_wdata;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    localparam int AW = 6;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    logic [DW-1:0] mem [0:63];
    logic          m1_leak = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM model: address registered at edge E, data out after E+1.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
        if (ram_we && ram_addr == 6'd20) m1_leak <= 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        req0 = 1;
        @(negedge clk);
        n_total++;
        if ({gnt0, gnt1} !== 2'b00) $display("FAIL reset_gnt: got %b want 00", {gnt0, gnt1});
        else n_pass++;
        n_total++;
        if ({ram_we, ram_addr, ram_wdata} !== '0)
            $display("FAIL reset_ramport: got we=%b addr=%0d wdata=%h want 0", ram_we, ram_addr, ram_wdata);
        else n_pass++;
        n_total++;
        if ({rvalid0, rvalid1, rdata0, rdata1} !== '0)
            $display("FAIL reset_resp: got rv=%b%b rd0=%h rd1=%h want 0", rvalid0, rvalid1, rdata0, rdata1);
        else n_pass++;
        tick();
        rst_n = 1;
        req0 = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_total++;
            if ({ram_we, gnt0, gnt1, rvalid0, rvalid1} !== 5'b0)
                $display("FAIL idle_cycle%0d: got we=%b gnt=%b%b rv=%b%b want 0", i, ram_we, gnt1, gnt0, rvalid1, rvalid0);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_write_read_m0();
        req0 = 1; we0 = 1; addr0 = 6'd5; wdata0 = 8'hA5;
        @(negedge clk);
        n_total++;
        if ({gnt1, gnt0} !== 2'b01) $display("FAIL wr_gnt: got %b want 01", {gnt1, gnt0});
        else n_pass++;
        tick();
        we0 = 0;
        @(negedge clk);
        n_total++;
        if ({gnt1, gnt0} !== 2'b01) $display("FAIL rd_gnt: got %b want 01", {gnt1, gnt0});
        else n_pass++;
        n_total++;
        if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 6'd5, 8'hA5})
            $display("FAIL wr_port: got we=%b addr=%0d wdata=%h want 1/5/a5", ram_we, ram_addr, ram_wdata);
        else n_pass++;
        tick();
        req0 = 0;
        @(negedge clk);
        n_total++;
        if ({ram_we, ram_addr, rvalid0} !== {1'b0, 6'd5, 1'b0})
            $display("FAIL rd_port: got we=%b addr=%0d rv0=%b want 0/5/0", ram_we, ram_addr, rvalid0);
        else n_pass++;
        tick();
        @(negedge clk);
        n_total++;
        if ({rvalid0, rdata0, rvalid1, rdata1} !== {1'b1, 8'hA5, 1'b0, 8'h00})
            $display("FAIL rd_resp: got rv0=%b rd0=%h rv1=%b rd1=%h want 1/a5/0/00", rvalid0, rdata0, rvalid1, rdata1);
        else n_pass++;
        n_total++;
        if ({ram_we, ram_addr} !== {1'b0, 6'd5})
            $display("FAIL idle_hold: got we=%b addr=%0d want 0/5", ram_we, ram_addr);
        else n_pass++;
        tick();
        @(negedge clk);
        n_total++;
        if ({rvalid0, rvalid1} !== 2'b00) $display("FAIL rd_strobe_len: got %b want 00", {rvalid1, rvalid0});
        else n_pass++;
        tick();
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic test_contention();
        // Preload addresses 1 and 2 through master 0.
        req0 = 1; we0 = 1; addr0 = 6'd1; wdata0 = 8'h11;
        tick();
        addr0 = 6'd2; wdata0 = 8'h22;
        tick();
        idle_inputs();
        tick();
        do_reset();
        we0 = 0; we1 = 0; addr0 = 6'd1; addr1 = 6'd2;
        for (int k = 0; k < 8; k++) begin
            req0 = (k < 6);
            req1 = (k < 6);
            @(negedge clk);
            n_total++;
            if (k < 6) begin
                if ({gnt1, gnt0} !== ((k % 2 == 0) ? 2'b01 : 2'b10))
                    $display("FAIL cont_gnt%0d: got %b want %b", k, {gnt1, gnt0}, (k % 2 == 0) ? 2'b01 : 2'b10);
                else n_pass++;
            end else begin
                if ({gnt1, gnt0} !== 2'b00) $display("FAIL cont_gnt%0d: got %b want 00", k, {gnt1, gnt0});
                else n_pass++;
            end
            if (k >= 2) begin
                n_total++;
                if ((k % 2) == 0) begin
                    if ({rvalid0, rdata0, rvalid1, rdata1} !== {1'b1, 8'h11, 1'b0, 8'h00})
                        $display("FAIL cont_resp%0d: got rv0=%b rd0=%h rv1=%b rd1=%h want 1/11/0/00", k, rvalid0, rdata0, rvalid1, rdata1);
                    else n_pass++;
                end else begin
                    if ({rvalid0, rdata0, rvalid1, rdata1} !== {1'b0, 8'h00, 1'b1, 8'h22})
                        $display("FAIL cont_resp%0d: got rv0=%b rd0=%h rv1=%b rd1=%h want 0/00/1/22", k, rvalid0, rdata0, rvalid1, rdata1);
                    else n_pass++;
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_hazard_cross();
        req1 = 1; we1 = 1; addr1 = 6'd63; wdata1 = 8'h3C;
        @(negedge clk);
        n_total++;
        if ({gnt1, gnt0} !== 2'b10) $display("FAIL haz_wgnt: got %b want 10", {gnt1, gnt0});
        else n_pass++;
        tick();
        req1 = 0;
        req0 = 1; we0 = 0; addr0 = 6'd63;
        @(negedge clk);
        n_total++;
        if ({gnt1, gnt0} !== 2'b01) $display("FAIL haz_rgnt: got %b want 01", {gnt1, gnt0});
        else n_pass++;
        tick();
        req0 = 0;
        tick();
        @(negedge clk);
        n_total++;
        if ({rvalid0, rdata0, rvalid1} !== {1'b1, 8'h3C, 1'b0})
            $display("FAIL haz_resp: got rv0=%b rd0=%h rv1=%b want 1/3c/0", rvalid0, rdata0, rvalid1);
        else n_pass++;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_read();
        req0 = 1; we0 = 0; addr0 = 6'd5;
        @(negedge clk);
        n_total++;
        if (gnt0 !== 1'b1) $display("FAIL rmr_gnt: got %b want 1", gnt0);
        else n_pass++;
        tick();
        req0 = 0;
        rst_n = 0;
        @(negedge clk);
        n_total++;
        if ({rvalid0, rvalid1, ram_addr} !== {2'b00, 6'd0})
            $display("FAIL rmr_inreset: got rv=%b%b addr=%0d want 00/0", rvalid1, rvalid0, ram_addr);
        else n_pass++;
        tick();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if ({rvalid0, rvalid1} !== 2'b00)
                $display("FAIL rmr_rvalid%0d: got %b%b want 00", i, rvalid1, rvalid0);
            else n_pass++;
            tick();
        end
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 6'd1; addr1 = 6'd2;
        @(negedge clk);
        n_total++;
        if ({gnt1, gnt0} !== 2'b01) $display("FAIL rmr_conflict: got %b want 01", {gnt1, gnt0});
        else n_pass++;
        tick();
        idle_inputs();
        tick(); tick(); tick();
    endtask

    task automatic test_withdrawn();
        // Master 1 write first so master 0 is owed the next conflict.
        req1 = 1; we1 = 1; addr1 = 6'd30; wdata1 = 8'h55;
        @(negedge clk);
        n_total++;
        if ({gnt1, gnt0} !== 2'b10) $display("FAIL wd_setup: got %b want 10", {gnt1, gnt0});
        else n_pass++;
        tick();
        req0 = 1; we0 = 1; addr0 = 6'd10; wdata0 = 8'h77;
        req1 = 1; we1 = 1; addr1 = 6'd20; wdata1 = 8'h99;
        @(negedge clk);
        n_total++;
        if ({gnt1, gnt0} !== 2'b01) $display("FAIL wd_gnt: got %b want 01", {gnt1, gnt0});
        else n_pass++;
        tick();
        idle_inputs();
        @(negedge clk);
        n_total++;
        if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 6'd10, 8'h77})
            $display("FAIL wd_port: got we=%b addr=%0d wdata=%h want 1/10/77", ram_we, ram_addr, ram_wdata);
        else n_pass++;
        tick();
        @(negedge clk);
        n_total++;
        if ({ram_we, ram_addr, ram_wdata} !== {1'b0, 6'd10, 8'h77})
            $display("FAIL wd_hold: got we=%b addr=%0d wdata=%h want 0/10/77", ram_we, ram_addr, ram_wdata);
        else n_pass++;
        tick();
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 6'd10; addr1 = 6'd30;
        @(negedge clk);
        n_total++;
        if ({gnt1, gnt0} !== 2'b10) $display("FAIL wd_pointer: got %b want 10", {gnt1, gnt0});
        else n_pass++;
        tick();
        idle_inputs();
        tick();
        @(negedge clk);
        n_total++;
        if ({rvalid1, rdata1} !== {1'b1, 8'h55})
            $display("FAIL wd_rd1: got rv1=%b rd1=%h want 1/55", rvalid1, rdata1);
        else n_pass++;
        tick();
        n_total++;
        if (m1_leak !== 1'b0) $display("FAIL wd_leak: got %b want 0", m1_leak);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_read_m0();
        test_contention();
        test_hazard_cross();
        test_reset_mid_read();
        test_withdrawn();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
